// File: rtl/zjh_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller:
// decoder enable codes, scan states and the active-low hex glyph table.
package zjh_scan_pkg;

  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  // Entry k is the {dp,g,f,e,d,c,b,a} pattern for hex digit k, dp off.
  localparam logic [15:0][7:0] GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/zjh_seg7_enc.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module zjh_seg7_enc
  import zjh_scan_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dot,
  output logic [7:0] seg
);

  always_comb begin
    seg = GLYPH[nib];
    if (dot) seg[7] = 1'b0;
  end

endmodule

// File: rtl/zjh_digit_scan.sv
// Dynamic-scan controller for an 8-digit multiplexed seven-segment display
// driving a 3-to-8 decoder, with per-digit blanking and per-frame snapshot.
//
// state | meaning
// IDLE  | display off, waiting for run
// SHOW  | selected digit lit for DIV cycles
// GAP   | all digits dark for BLANK cycles before advancing
module zjh_digit_scan
  import zjh_scan_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 8,
  parameter int NDIG  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  output logic [2:0]  sel,
  output logic [2:0]  en,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = $clog2(CMAX + 1);

  scan_state_t   state, state_next;
  logic [CW-1:0] cnt;
  logic [31:0]   data_buf, data_buf_next;
  logic [7:0]    dp_buf, dp_buf_next;
  logic [2:0]    sel_next;
  logic [7:0]    glyph;
  logic          show_end, gap_end, advance, last, wrap;

  assign show_end = (state == SHOW) && (cnt == CW'(DIV - 1));
  assign gap_end  = (state == GAP) && (cnt == CW'(BLANK - 1));
  assign advance  = run && (gap_end || (show_end && (BLANK == 0)));
  assign last     = (sel == 3'(NDIG - 1));
  assign wrap     = advance && last;

  always_comb begin
    state_next    = state;
    sel_next      = sel;
    data_buf_next = data_buf;
    dp_buf_next   = dp_buf;
    if (!run) begin
      state_next = IDLE;
      sel_next   = 3'd0;
    end else if (state == IDLE) begin
      state_next    = SHOW;
      sel_next      = 3'd0;
      data_buf_next = data;
      dp_buf_next   = dp;
    end else if (advance) begin
      state_next = SHOW;
      if (last) begin
        sel_next      = 3'd0;
        data_buf_next = data;
        dp_buf_next   = dp;
      end else begin
        sel_next = sel + 3'd1;
      end
    end else if (show_end) begin
      state_next = GAP;
    end
  end

  // Encode from the next-cycle buffer so the new snapshot lands on seg
  // in the same cycle sel wraps to 0.
  zjh_seg7_enc u_enc (
    .nib (data_buf_next[{sel_next, 2'b00} +: 4]),
    .dot (dp_buf_next[sel_next]),
    .seg (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      data_buf   <= '0;
      dp_buf     <= '0;
      sel        <= 3'd0;
      en         <= EN_OFF;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      data_buf   <= data_buf_next;
      dp_buf     <= dp_buf_next;
      sel        <= sel_next;
      en         <= (state_next == SHOW) ? EN_ON : EN_OFF;
      seg        <= (state_next == SHOW) ? glyph : 8'hFF;
      frame_done <= wrap;
      if ((state_next != state) || advance) cnt <= '0;
      else if (cnt != CW'(CMAX))            cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_zjh_digit_scan.sv
// Self-checking bench: frame-time model per DUT, compared every cycle,
// plus hand-computed checkpoints on the main configuration.
module tb_zjh_digit_scan;

  localparam int DIV1 = 4, BLANK1 = 2, NDIG1 = 8;
  localparam int DIV2 = 4, BLANK2 = 0, NDIG2 = 1;

  localparam logic [7:0] GL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    logic [2:0] sel;
    logic [2:0] en;
    logic [7:0] seg;
    logic       fd;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n, run1, run2;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [2:0]  sel1, en1, sel2, en2;
  logic [7:0]  seg1, seg2;
  logic        fd1, fd2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  zjh_digit_scan #(.DIV(DIV1), .BLANK(BLANK1), .NDIG(NDIG1)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .data(data), .dp(dp),
    .sel(sel1), .en(en1), .seg(seg1), .frame_done(fd1)
  );

  zjh_digit_scan #(.DIV(DIV2), .BLANK(BLANK2), .NDIG(NDIG2)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2), .data(data), .dp(dp),
    .sel(sel2), .en(en2), .seg(seg2), .frame_done(fd2)
  );

  // Model: t counts cycles since the first SHOW; position in the frame
  // follows directly from t by division.
  function automatic out_t expect_out(input bit act, input int t, input int div,
                                      input int blank, input int ndig,
                                      input logic [31:0] d, input logic [7:0] p);
    out_t o;
    int per, frm, dig, ph;
    logic [3:0] nib;
    o.sel = 3'd0; o.en = 3'b011; o.seg = 8'hFF; o.fd = 1'b0;
    if (act) begin
      per = div + blank;
      frm = per * ndig;
      dig = (t % frm) / per;
      ph  = t % per;
      o.sel = 3'(dig);
      o.fd  = (t > 0) && (t % frm == 0);
      if (ph < div) begin
        nib   = d[dig*4 +: 4];
        o.en  = 3'b100;
        o.seg = GL[nib];
        if (p[dig]) o.seg[7] = 1'b0;
      end
    end
    return o;
  endfunction

  bit          a1, a2;
  int          t1, t2;
  logic [31:0] sd1, sd2;
  logic [7:0]  sp1, sp2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1 <= 0; t1 <= 0; sd1 <= '0; sp1 <= '0;
    end else if (!run1) begin
      a1 <= 0;
    end else if (!a1) begin
      a1 <= 1; t1 <= 0; sd1 <= data; sp1 <= dp;
    end else begin
      t1 <= t1 + 1;
      if ((t1 + 1) % ((DIV1 + BLANK1) * NDIG1) == 0) begin
        sd1 <= data; sp1 <= dp;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a2 <= 0; t2 <= 0; sd2 <= '0; sp2 <= '0;
    end else if (!run2) begin
      a2 <= 0;
    end else if (!a2) begin
      a2 <= 1; t2 <= 0; sd2 <= data; sp2 <= dp;
    end else begin
      t2 <= t2 + 1;
      if ((t2 + 1) % ((DIV2 + BLANK2) * NDIG2) == 0) begin
        sd2 <= data; sp2 <= dp;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    out_t e1, e2;
    e1 = expect_out(a1, t1, DIV1, BLANK1, NDIG1, sd1, sp1);
    e2 = expect_out(a2, t2, DIV2, BLANK2, NDIG2, sd2, sp2);
    chk("m1_sel", 32'(sel1), 32'(e1.sel));
    chk("m1_en",  32'(en1),  32'(e1.en));
    chk("m1_seg", 32'(seg1), 32'(e1.seg));
    chk("m1_fd",  32'(fd1),  32'(e1.fd));
    chk("m2_sel", 32'(sel2), 32'(e2.sel));
    chk("m2_en",  32'(en2),  32'(e2.en));
    chk("m2_seg", 32'(seg2), 32'(e2.seg));
    chk("m2_fd",  32'(fd2),  32'(e2.fd));
  end

  // Wait (bounded) until DUT1's model is running at frame time k.
  task automatic goto(input int k);
    int n = 0;
    @(negedge clk);
    while (!(a1 && t1 == k) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("goto_timeout", 32'(a1 && t1 == k), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; run1 = 1'b0; run2 = 1'b0; data = '0; dp = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_en",  32'(en1),  32'h3);
    chk("rst_seg", 32'(seg1), 32'hFF);
    chk("rst_sel", 32'(sel1), 32'h0);
    chk("rst_fd",  32'(fd1),  32'h0);
    repeat (20) @(negedge clk);
    #1 data = 32'h76543210; dp = 8'h00; run1 = 1'b1; run2 = 1'b1;

    goto(0);
    chk("d0_seg", 32'(seg1), 32'hC0);
    chk("d0_en",  32'(en1),  32'h4);
    chk("d0_sel", 32'(sel1), 32'h0);
    goto(4);
    chk("gap_en",  32'(en1),  32'h3);
    chk("gap_seg", 32'(seg1), 32'hFF);
    chk("gap_sel", 32'(sel1), 32'h0);
    chk("n1_fd",   32'(fd2),  32'h1);
    chk("n1_en",   32'(en2),  32'h4);
    goto(6);
    chk("d1_sel", 32'(sel1), 32'h1);
    chk("d1_seg", 32'(seg1), 32'hF9);
    chk("d1_fd",  32'(fd1),  32'h0);
    goto(20);
    #1 data = 32'hFFFFFFFF;
    goto(24);
    chk("d4_sel", 32'(sel1), 32'h4);
    chk("d4_old", 32'(seg1), 32'h99);
    goto(42);
    chk("d7_old", 32'(seg1), 32'hF8);
    goto(48);
    chk("wrap_fd",  32'(fd1),  32'h1);
    chk("wrap_sel", 32'(sel1), 32'h0);
    chk("wrap_seg", 32'(seg1), 32'h8E);
    goto(60);
    #1 data = 32'h76543210; dp = 8'h04;
    goto(108);
    chk("dp2_seg", 32'(seg1), 32'h24);
    goto(114);
    chk("dp3_seg", 32'(seg1), 32'hB0);
    goto(127);
    #1 run1 = 1'b0;
    @(negedge clk);
    chk("stop_en",  32'(en1),  32'h3);
    chk("stop_seg", 32'(seg1), 32'hFF);
    chk("stop_sel", 32'(sel1), 32'h0);
    #1 run1 = 1'b1;
    @(negedge clk);
    chk("restart_seg", 32'(seg1), 32'hC0);
    chk("restart_sel", 32'(sel1), 32'h0);
    goto(9);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_en",  32'(en1),  32'h3);
    chk("arst_seg", 32'(seg1), 32'hFF);
    chk("arst_sel", 32'(sel1), 32'h0);
    chk("arst_en2", 32'(en2),  32'h3);
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 19) == 0) data = $urandom;
      if ($urandom_range(0, 19) == 0) dp = 8'($urandom);
      if (run1) begin
        if ($urandom_range(0, 149) == 0) run1 = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        run1 = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) run2 = ~run2;
      else if (!run2) run2 = 1'b1;
    end
    run1 = 1'b0; run2 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zjh_digit_scan.md
# zjh_digit_scan

Dynamic-scan controller for an 8-digit multiplexed seven-segment display. It sits directly upstream of the 3-to-8 line decoder: its `sel` drives the decoder address inputs and its `en` drives the decoder's three enable inputs, so exactly one active-low digit line is driven at a time. It also drives the shared segment bus with the encoded glyph for the selected digit. A blanking gap between digits suppresses ghosting. Display data is snapshotted once per frame so a digit never tears mid-frame.

## Interface
- `DIV`, 50000 — clock cycles each digit is shown; legal range ≥ 1.
- `BLANK`, 8 — clock cycles of blanking after each digit; 0 disables blanking.
- `NDIG`, 8 — number of scanned digits, 1..8; `sel` counts 0..NDIG-1.

- `clk` input 1 — single clock; all state on rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `run` input 1 — level; 1 = scan, 0 = display off.
- `data` input 32 — eight hex nibbles; digit k = `data[4k+3:4k]`.
- `dp` input 8 — decimal point per digit, 1 = lit.
- `sel` output 3 — digit address to decoder A[2:0].
- `en` output 3 — decoder enables {E2,E1,E0}: 3'b100 = enabled, 3'b011 = disabled.
- `seg` output 8 — {dp,g,f,e,d,c,b,a}, active-low, 1 = segment off.
- `frame_done` output 1 — one-cycle pulse at each frame wrap.

## Operation
- FSM states: IDLE, SHOW, GAP.
- IDLE: `en`=011, `seg`=8'hFF, `sel`=0. When `run`=1: snapshot `data`/`dp` into the frame buffer, go to SHOW with `sel`=0.
- SHOW: `en`=100, `seg`=encode(buffer nibble[sel], buffer dp[sel]). Hold for exactly DIV cycles, then go to GAP, or to the next digit directly if BLANK=0.
- GAP: `en`=011, `seg`=8'hFF, `sel` held. Hold BLANK cycles, then advance.
- Advance: if `sel`=NDIG-1, set `sel`=0, re-snapshot `data`/`dp`, pulse `frame_done`; otherwise `sel`+1. Next state is SHOW.
- `run`=0 in any state: next cycle IDLE, outputs as in IDLE. Any partial frame is discarded.
- Encoding: hex 0–F to standard segments (0=8'hC0, 1=8'hF9 … 8=8'h80, F=8'h8E with dp off). `dp`=1 clears bit 7.
- Dwell counter width is $clog2(max(DIV,BLANK)+1). It resets to 0 on every state change; no wrap beyond the terminal count.

## Timing
- Reset values: `sel`=0, `en`=3'b011, `seg`=8'hFF, `frame_done`=0, state IDLE, frame buffer all zero.
- All outputs are registered; no combinational path from input to output.
- `run` rises in cycle n: SHOW of digit 0 is visible at the outputs in cycle n+1.
- Per-digit period: DIV+BLANK cycles. Frame period: NDIG·(DIV+BLANK) cycles.
- `frame_done` is high in the same cycle `sel` returns to 0 and the new snapshot first appears on `seg`.
- `data` changes mid-frame have no effect until the next wrap.
- `en` and `seg` change in the same cycle; `sel` changes only while `en`=011 when BLANK>0.
- `rst_n` asserted mid-frame: all outputs take reset values immediately (asynchronously). The first SHOW follows one cycle after release if `run`=1.
- NDIG=1: `sel` stays 0, and `frame_done` pulses every DIV+BLANK cycles.

## Structure
- Package `zjh_scan_pkg` holds:
  - `EN_ON`=3'b100 and `EN_OFF`=3'b011;
  - state enum `scan_state_t`;
  - the 16-entry active-low glyph constant.
- Sub-module `zjh_seg7_enc`: combinational nibble+dp to 8-bit segment encoder, instantiated once on the buffered nibble. Its output is registered in the top-level block.

## Test plan
Common setup for all scenarios: DIV=4, BLANK=2, NDIG=8.
- Reset, `run`=0 for 20 cycles → `en`=011, `seg`=FF, `sel`=0, `frame_done`=0 throughout.
- `data`=32'h76543210, `dp`=0, `run`=1 → `sel` sequence 0..7; each digit shows 4 cycles with `en`=100 and glyphs C0,F9,A4,B0,99,92,82,F8, followed by 2 cycles of `en`=011 and `seg`=FF. `frame_done` pulses once every 48 cycles.
- Change `data` to 32'hFFFFFFFF during digit 3 → digits 3–7 keep the old glyphs; after the wrap all digits show 8E.
- `dp`=8'h04 → digit 2 `seg`=8'h24; all other digits have bit 7 set.
- Drop `run` during digit 5 → next cycle `en`=011, `seg`=FF, `sel`=0. Re-raising `run` restarts at digit 0.
- Assert `rst_n`=0 asynchronously mid-SHOW → outputs go to reset values before the next clock edge. Separate case: rebuild with BLANK=0, NDIG=1 → `en` stays 100 continuously and `frame_done` pulses every 4 cycles.
